// File: rtl/chess_clock.sv
// Two-player countdown game clock. It decrements the side-to-move once per game second,
// credits a per-move increment, and flags the first player whose time reaches zero.
module chess_clock #(
   parameter int unsigned TICKS_PER_SEC     = 100000000,
   parameter int unsigned START_SECONDS     = 600,
   parameter int unsigned INCREMENT_SECONDS = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        turn,
   input  logic        loading,
   input  logic        moveSound,
   input  logic [1:0]  checkmate,
   output logic [1:0]  timeout,
   output logic [11:0] whiteSeconds,
   output logic [11:0] blackSeconds,
   output logic        running
);

   localparam int unsigned PW = $clog2(TICKS_PER_SEC);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
   localparam logic [11:0] START_VAL = 12'(START_SECONDS);

   typedef enum logic [1:0] {StIdle, StRun, StFlag, StDone} state_t;

   state_t        state;
   logic [PW-1:0] presc;
   logic          turn_q;
   logic          turn_chg;
   logic          tick;
   logic [11:0]   white_nxt;
   logic [11:0]   black_nxt;
   logic          flag_nxt;

   // Increment saturates at 4095 before the tick decrement, so both land in one update.
   function automatic logic [11:0] upd(input logic [11:0] s, input logic inc, input logic dec);
      logic [12:0] sum;
      logic [11:0] sat;
      sum = {1'b0, s} + (inc ? 13'(INCREMENT_SECONDS) : 13'd0);
      sat = sum[12] ? 12'hFFF : sum[11:0];
      return dec ? sat - 12'd1 : sat;
   endfunction

   always_comb begin
      turn_chg  = (turn != turn_q);
      tick      = (presc == PRESC_MAX) && !loading && !turn_chg;
      white_nxt = upd(whiteSeconds, moveSound && !turn, tick && !turn);
      black_nxt = upd(blackSeconds, moveSound && turn, tick && turn);
      flag_nxt  = tick && (turn ? (black_nxt == 12'd0) : (white_nxt == 12'd0));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= StIdle;
         presc        <= '0;
         turn_q       <= 1'b0;
         whiteSeconds <= START_VAL;
         blackSeconds <= START_VAL;
         timeout      <= 2'b00;
         running      <= 1'b0;
      end else begin
         turn_q <= turn;
         case (state)
            StIdle: begin
               if (checkmate != 2'b00) begin
                  state <= StDone;
               end else if (start) begin
                  state   <= StRun;
                  running <= 1'b1;
                  presc   <= '0;
               end
            end
            StRun: begin
               if (checkmate != 2'b00) begin
                  state   <= StDone;
                  running <= 1'b0;
               end else begin
                  // A turn change restarts the second for the new side to move.
                  if (turn_chg) begin
                     presc <= '0;
                  end else if (!loading) begin
                     presc <= tick ? '0 : presc + PW'(1);
                  end
                  whiteSeconds <= white_nxt;
                  blackSeconds <= black_nxt;
                  if (flag_nxt) begin
                     timeout[turn] <= 1'b1;
                     state         <= StFlag;
                     running       <= 1'b0;
                  end
               end
            end
            StFlag: ;
            StDone: ;
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_chess_clock.sv
// Scoreboard bench for chess_clock: three instances cover the base, increment and
// saturation parameter sets, all driven from shared inputs.
module tb_chess_clock;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, turn, loading, moveSound;
   logic [1:0]  checkmate;
   logic [1:0]  a_to, b_to, c_to;
   logic [11:0] a_w, a_b, b_w, b_b, c_w, c_b;
   logic        a_run, b_run, c_run;

   chess_clock #(.TICKS_PER_SEC(4), .START_SECONDS(3), .INCREMENT_SECONDS(0)) dut_a (
      .clk(clk), .reset(reset), .start(start), .turn(turn), .loading(loading),
      .moveSound(moveSound), .checkmate(checkmate), .timeout(a_to),
      .whiteSeconds(a_w), .blackSeconds(a_b), .running(a_run));

   chess_clock #(.TICKS_PER_SEC(4), .START_SECONDS(3), .INCREMENT_SECONDS(2)) dut_b (
      .clk(clk), .reset(reset), .start(start), .turn(turn), .loading(loading),
      .moveSound(moveSound), .checkmate(checkmate), .timeout(b_to),
      .whiteSeconds(b_w), .blackSeconds(b_b), .running(b_run));

   chess_clock #(.TICKS_PER_SEC(4), .START_SECONDS(4094), .INCREMENT_SECONDS(5)) dut_c (
      .clk(clk), .reset(reset), .start(start), .turn(turn), .loading(loading),
      .moveSound(moveSound), .checkmate(checkmate), .timeout(c_to),
      .whiteSeconds(c_w), .blackSeconds(c_b), .running(c_run));

   typedef struct {
      int          at;
      logic [11:0] w;
      logic [11:0] b;
      logic [1:0]  to;
      logic        run;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic void push(int at, logic [11:0] w, logic [11:0] b, logic [1:0] to,
                                logic run);
      exp_t x;
      x.at = at; x.w = w; x.b = b; x.to = to; x.run = run;
      sb.push_back(x);
   endfunction

   task automatic do_reset();
      turn = 1'b0; loading = 1'b0; moveSound = 1'b0; checkmate = 2'b00; start = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic do_start(output int n);
      start = 1'b1;
      step();
      start = 1'b0;
      n = cyc;
   endtask

   task automatic drain_leftover(input string name);
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL %s: %0d expectations never reached, first due at cyc %0d now %0d",
                  name, sb.size(), sb[0].at, cyc);
         sb.delete();
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({a_w, a_b, a_to, a_run} !== {12'd3, 12'd3, 2'b00, 1'b0}) begin
         n_err++;
         $display("FAIL reset_a: got w=%0d b=%0d to=%b run=%b want 3 3 00 0",
                  a_w, a_b, a_to, a_run);
      end
      n_cmp++;
      if ({c_w, c_b, c_to, c_run} !== {12'd4094, 12'd4094, 2'b00, 1'b0}) begin
         n_err++;
         $display("FAIL reset_c: got w=%0d b=%0d to=%b run=%b want 4094 4094 00 0",
                  c_w, c_b, c_to, c_run);
      end
   endtask

   task automatic test_white_flag();
      int n;
      do_reset();
      do_start(n);
      push(n, 3, 3, 2'b00, 1);      push(n + 3, 3, 3, 2'b00, 1);
      push(n + 4, 2, 3, 2'b00, 1);  push(n + 7, 2, 3, 2'b00, 1);
      push(n + 8, 1, 3, 2'b00, 1);  push(n + 11, 1, 3, 2'b00, 1);
      push(n + 12, 0, 3, 2'b01, 0); push(n + 22, 0, 3, 2'b01, 0);
      push(n + 32, 0, 3, 2'b01, 0);
      for (int k = 0; k <= 32; k++) begin
         if (k != 0) step();
         while (sb.size() != 0 && sb[0].at == cyc) begin
            e = sb.pop_front();
            n_cmp++;
            if ({a_w, a_b, a_to, a_run} !== {e.w, e.b, e.to, e.run}) begin
               n_err++;
               $display("FAIL white_flag cyc+%0d: got w=%0d b=%0d to=%b run=%b want %0d %0d %b %b",
                        cyc - n, a_w, a_b, a_to, a_run, e.w, e.b, e.to, e.run);
            end
         end
      end
      drain_leftover("white_flag");
   endtask

   task automatic test_loading_black();
      int n;
      do_reset();
      do_start(n);
      push(n + 3, 3, 3, 2'b00, 1);  push(n + 13, 3, 3, 2'b00, 1);
      push(n + 14, 2, 3, 2'b00, 1); push(n + 19, 2, 3, 2'b00, 1);
      push(n + 20, 2, 2, 2'b00, 1); push(n + 24, 2, 1, 2'b00, 1);
      push(n + 27, 2, 1, 2'b00, 1); push(n + 28, 2, 0, 2'b10, 0);
      push(n + 30, 2, 0, 2'b10, 0);
      for (int k = 0; k <= 30; k++) begin
         if (k != 0) step();
         while (sb.size() != 0 && sb[0].at == cyc) begin
            e = sb.pop_front();
            n_cmp++;
            if ({a_w, a_b, a_to, a_run} !== {e.w, e.b, e.to, e.run}) begin
               n_err++;
               $display("FAIL loading_black cyc+%0d: got w=%0d b=%0d to=%b run=%b want %0d %0d %b %b",
                        cyc - n, a_w, a_b, a_to, a_run, e.w, e.b, e.to, e.run);
            end
         end
         loading = (k >= 1 && k <= 10);
         turn    = (k >= 15);
      end
      drain_leftover("loading_black");
   endtask

   task automatic test_increment();
      int n;
      do_reset();
      do_start(n);
      push(n + 4, 2, 3, 2'b00, 1);  push(n + 8, 1, 3, 2'b00, 1);
      push(n + 11, 1, 3, 2'b00, 1); push(n + 12, 2, 3, 2'b00, 1);
      push(n + 15, 2, 3, 2'b00, 1); push(n + 16, 1, 3, 2'b00, 1);
      for (int k = 0; k <= 16; k++) begin
         if (k != 0) step();
         while (sb.size() != 0 && sb[0].at == cyc) begin
            e = sb.pop_front();
            n_cmp++;
            if ({b_w, b_b, b_to, b_run} !== {e.w, e.b, e.to, e.run}) begin
               n_err++;
               $display("FAIL increment cyc+%0d: got w=%0d b=%0d to=%b run=%b want %0d %0d %b %b",
                        cyc - n, b_w, b_b, b_to, b_run, e.w, e.b, e.to, e.run);
            end
         end
         moveSound = (k == 11);
      end
      drain_leftover("increment");
   endtask

   task automatic test_checkmate();
      int n;
      do_reset();
      do_start(n);
      push(n + 8, 1, 3, 2'b00, 1);  push(n + 11, 1, 3, 2'b00, 1);
      push(n + 12, 1, 3, 2'b00, 0); push(n + 20, 1, 3, 2'b00, 0);
      for (int k = 0; k <= 20; k++) begin
         if (k != 0) step();
         while (sb.size() != 0 && sb[0].at == cyc) begin
            e = sb.pop_front();
            n_cmp++;
            if ({a_w, a_b, a_to, a_run} !== {e.w, e.b, e.to, e.run}) begin
               n_err++;
               $display("FAIL checkmate cyc+%0d: got w=%0d b=%0d to=%b run=%b want %0d %0d %b %b",
                        cyc - n, a_w, a_b, a_to, a_run, e.w, e.b, e.to, e.run);
            end
         end
         checkmate = (k == 11) ? 2'b01 : 2'b00;
         start     = (k == 14);
      end
      drain_leftover("checkmate");
   endtask

   task automatic test_saturation_reset();
      int n;
      do_reset();
      do_start(n);
      push(n, 4094, 4094, 2'b00, 1);     push(n + 1, 4095, 4094, 2'b00, 1);
      push(n + 2, 4095, 4094, 2'b00, 1); push(n + 3, 4094, 4094, 2'b00, 0);
      push(n + 9, 4094, 4094, 2'b00, 0); push(n + 10, 4094, 4094, 2'b00, 1);
      push(n + 13, 4094, 4094, 2'b00, 1); push(n + 14, 4093, 4094, 2'b00, 1);
      for (int k = 0; k <= 14; k++) begin
         if (k != 0) step();
         while (sb.size() != 0 && sb[0].at == cyc) begin
            e = sb.pop_front();
            n_cmp++;
            if ({c_w, c_b, c_to, c_run} !== {e.w, e.b, e.to, e.run}) begin
               n_err++;
               $display("FAIL sat_reset cyc+%0d: got w=%0d b=%0d to=%b run=%b want %0d %0d %b %b",
                        cyc - n, c_w, c_b, c_to, c_run, e.w, e.b, e.to, e.run);
            end
         end
         moveSound = (k == 0);
         reset     = (k == 2);
         start     = (k == 9);
      end
      drain_leftover("sat_reset");
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; turn = 1'b0; loading = 1'b0;
      moveSound = 1'b0; checkmate = 2'b00;
      test_reset();
      test_white_flag();
      test_loading_black();
      test_increment();
      test_checkmate();
      test_saturation_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
